// File: rtl/term_char_engine_if.sv
// ------------------------------------------------------------------
// term_char_engine_if : byte input and display command bus
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface term_char_engine_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [10:0] cursor;
  logic        wr_start;
  logic [10:0] wr_begin;
  logic [10:0] wr_end;
  logic [7:0]  wr_data;
  logic [7:0]  wr_offset;
  logic        wr_complete;

  modport master (
    input  rx_data, rx_valid, wr_complete,
    output rx_ready, cursor, wr_start, wr_begin, wr_end, wr_data, wr_offset
  );

  modport slave (
    output rx_data, rx_valid, wr_complete,
    input  rx_ready, cursor, wr_start, wr_begin, wr_end, wr_data, wr_offset
  );
endinterface

`default_nettype wire

// File: rtl/term_char_engine.sv
// ------------------------------------------------------------------
// term_char_engine : interprets a terminal byte stream into cursor
//                    moves and fill/copy commands for a text display
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module term_char_engine #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 25,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  wire logic               clk100,
  input  wire logic               rst,
  term_char_engine_if.master      bus
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COLS - 1);
  localparam logic [10:0]      CELLS      = 11'(COLS * ROWS);
  localparam logic [10:0]      LAST_BASE  = 11'(COLS * (ROWS - 1));
  localparam logic [10:0]      COLS_C     = 11'(COLS);
  localparam logic [10:0]      COLS_M1    = 11'(COLS - 1);
  localparam logic [7:0]       ROW_OFFSET = 8'(COLS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CMD       = 3'd1,
    WAIT      = 3'd2,
    SCRL_CPY  = 3'd3,
    SCRL_WAIT = 3'd4,
    FILL      = 3'd5,
    FILL_WAIT = 3'd6
  } state_t;

  state_t            state_q,     state_d;
  logic [ROW_W-1:0]  row_q,       row_d;
  logic [COL_W-1:0]  col_q,       col_d;
  logic [10:0]       cursor_q,    cursor_d;
  logic              rx_ready_q,  rx_ready_d;
  logic              wr_start_q,  wr_start_d;
  logic [10:0]       wr_begin_q,  wr_begin_d;
  logic [10:0]       wr_end_q,    wr_end_d;
  logic [7:0]        wr_data_q,   wr_data_d;
  logic [7:0]        wr_offset_q, wr_offset_d;

  logic              accept;
  logic              is_print;
  logic [7:0]        rx_byte;

  assign rx_byte  = bus.rx_data;
  assign accept   = bus.rx_valid && rx_ready_q;
  assign is_print = (rx_byte >= 8'h20) && (rx_byte <= 8'h7E);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    cursor_d    = cursor_q;
    wr_start_d  = 1'b0;
    wr_begin_d  = wr_begin_q;
    wr_end_d    = wr_end_q;
    wr_data_d   = wr_data_q;
    wr_offset_d = wr_offset_q;

    // Commands are loaded on the edge that enters the issue state, so
    // wr_start and wr_* are visible together during that state.
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_print) begin
            wr_begin_d  = cursor_q;
            wr_end_d    = cursor_q + 11'd1;
            wr_data_d   = rx_byte;
            wr_offset_d = 8'd0;
            wr_start_d  = 1'b1;
            state_d     = CMD;
          end else begin
            unique case (rx_byte)
              8'h0D: begin
                col_d    = '0;
                cursor_d = cursor_q - 11'(col_q);
              end
              8'h0A: begin
                if (row_q < LAST_ROW) begin
                  row_d    = row_q + 1'b1;
                  cursor_d = cursor_q + COLS_C;
                end else begin
                  wr_begin_d  = 11'd0;
                  wr_end_d    = LAST_BASE;
                  wr_offset_d = ROW_OFFSET;
                  wr_start_d  = 1'b1;
                  state_d     = SCRL_CPY;
                end
              end
              8'h08: begin
                if (col_q != '0) begin
                  col_d    = col_q - 1'b1;
                  cursor_d = cursor_q - 11'd1;
                end
              end
              8'h0C: begin
                row_d       = '0;
                col_d       = '0;
                cursor_d    = 11'd0;
                wr_begin_d  = 11'd0;
                wr_end_d    = CELLS;
                wr_data_d   = BLANK;
                wr_offset_d = 8'd0;
                wr_start_d  = 1'b1;
                state_d     = FILL;
              end
              default: ;
            endcase
          end
        end
      end

      CMD: state_d = WAIT;

      WAIT: begin
        if (bus.wr_complete) begin
          if (col_q < LAST_COL) begin
            col_d    = col_q + 1'b1;
            cursor_d = cursor_q + 11'd1;
            state_d  = IDLE;
          end else if (row_q < LAST_ROW) begin
            col_d    = '0;
            row_d    = row_q + 1'b1;
            cursor_d = cursor_q + 11'd1;
            state_d  = IDLE;
          end else begin
            // Wrote the last cell: cursor to start of the bottom row, then scroll.
            col_d       = '0;
            cursor_d    = cursor_q - COLS_M1;
            wr_begin_d  = 11'd0;
            wr_end_d    = LAST_BASE;
            wr_offset_d = ROW_OFFSET;
            wr_start_d  = 1'b1;
            state_d     = SCRL_CPY;
          end
        end
      end

      SCRL_CPY: state_d = SCRL_WAIT;

      SCRL_WAIT: begin
        if (bus.wr_complete) begin
          wr_begin_d  = LAST_BASE;
          wr_end_d    = CELLS;
          wr_data_d   = BLANK;
          wr_offset_d = 8'd0;
          wr_start_d  = 1'b1;
          state_d     = FILL;
        end
      end

      FILL: state_d = FILL_WAIT;

      FILL_WAIT: begin
        if (bus.wr_complete) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    rx_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      cursor_q    <= 11'd0;
      rx_ready_q  <= 1'b1;
      wr_start_q  <= 1'b0;
      wr_begin_q  <= 11'd0;
      wr_end_q    <= 11'd0;
      wr_data_q   <= 8'd0;
      wr_offset_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cursor_q    <= cursor_d;
      rx_ready_q  <= rx_ready_d;
      wr_start_q  <= wr_start_d;
      wr_begin_q  <= wr_begin_d;
      wr_end_q    <= wr_end_d;
      wr_data_q   <= wr_data_d;
      wr_offset_q <= wr_offset_d;
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.cursor    = cursor_q;
  assign bus.wr_start  = wr_start_q;
  assign bus.wr_begin  = wr_begin_q;
  assign bus.wr_end    = wr_end_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_offset = wr_offset_q;

endmodule

`default_nettype wire

// File: tb/tb_term_char_engine.sv
// ------------------------------------------------------------------
// tb_term_char_engine : drives bytes, answers display commands and
//                       compares against a row/column terminal model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_term_char_engine;
  localparam int COLS = 80;
  localparam int ROWS = 25;

  logic clk100 = 1'b0;
  logic rst    = 1'b1;
  always #5 clk100 = ~clk100;

  term_char_engine_if bus();

  term_char_engine #(.COLS(COLS), .ROWS(ROWS), .BLANK(8'h20)) dut (
    .clk100 (clk100),
    .rst    (rst),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int b;
    int e;
    int d;
    int o;
  } cmd_t;

  cmd_t exp_q[$];
  int   m_row = 0;
  int   m_col = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void push_cmd(input int b, input int e, input int d, input int o);
    cmd_t c;
    c.b = b; c.e = e; c.d = d; c.o = o;
    exp_q.push_back(c);
  endfunction

  function automatic void model_scroll();
    push_cmd(0, COLS * (ROWS - 1), 0, COLS);
    push_cmd(COLS * (ROWS - 1), COLS * ROWS, 8'h20, 0);
  endfunction

  // Terminal behaviour in row/column terms
  function automatic void model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_cmd(m_row * COLS + m_col, m_row * COLS + m_col + 1, b, 0);
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_row++;
        if (m_row == ROWS) begin
          m_row = ROWS - 1;
          model_scroll();
        end
      end
    end else begin
      case (b)
        8'h0D: m_col = 0;
        8'h0A: begin
          m_row++;
          if (m_row == ROWS) begin
            m_row = ROWS - 1;
            model_scroll();
          end
        end
        8'h08: if (m_col > 0) m_col--;
        8'h0C: begin
          m_row = 0;
          m_col = 0;
          push_cmd(0, COLS * ROWS, 8'h20, 0);
        end
        default: ;
      endcase
    end
  endfunction

  task automatic check_cmd(input cmd_t c);
    check_val("wr_start", bus.wr_start, 1);
    check_val("wr_begin", bus.wr_begin, c.b);
    check_val("wr_end", bus.wr_end, c.e);
    check_val("wr_offset", bus.wr_offset, c.o);
    if (c.o == 0) check_val("wr_data", bus.wr_data, c.d);
    check_val("rx_ready_busy", bus.rx_ready, 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   guard;
    int   d;
    cmd_t c;
    guard = 0;
    @(negedge clk100);
    while (!bus.rx_ready && guard < 50) begin
      @(negedge clk100);
      guard++;
    end
    check_val("rx_ready_before_send", bus.rx_ready, 1);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk100);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
    model_byte(b);
    @(negedge clk100);
    if (exp_q.size() == 0) begin
      check_val("no_cmd_wr_start", bus.wr_start, 0);
    end else begin
      while (exp_q.size() > 0) begin
        c = exp_q.pop_front();
        check_cmd(c);
        d = $urandom_range(0, 3);
        repeat (d + 1) begin
          @(negedge clk100);
          check_val("wr_start_pulse", bus.wr_start, 0);
        end
        bus.wr_complete = 1'b1;
        @(negedge clk100);
        bus.wr_complete = 1'b0;
      end
      check_val("wr_start_idle", bus.wr_start, 0);
    end
    check_val("rx_ready_after", bus.rx_ready, 1);
    check_val("cursor", bus.cursor, m_row * COLS + m_col);
  endtask

  task automatic goto_cell(input int r, input int c);
    send_byte(8'h0C);
    repeat (r) send_byte(8'h0A);
    repeat (c) send_byte(8'h2E);
  endtask

  initial begin
    int   pick;
    logic [7:0] rb;
    bus.rx_data     = 8'h00;
    bus.rx_valid    = 1'b0;
    bus.wr_complete = 1'b0;
    repeat (3) @(posedge clk100);
    @(negedge clk100);
    rst = 1'b0;
    check_val("reset_cursor", bus.cursor, 0);
    check_val("reset_wr_start", bus.wr_start, 0);
    check_val("reset_wr_begin", bus.wr_begin, 0);
    check_val("reset_wr_end", bus.wr_end, 0);
    check_val("reset_wr_data", bus.wr_data, 0);
    check_val("reset_wr_offset", bus.wr_offset, 0);
    check_val("reset_rx_ready", bus.rx_ready, 1);

    // Printable at home position
    send_byte(8'h41);
    check_val("t1_cursor", bus.cursor, 1);

    // Wrap from end of row 3
    goto_cell(3, 79);
    send_byte(8'h78);
    check_val("t2_cursor", bus.cursor, 320);

    // LF on the bottom row scrolls, column kept
    goto_cell(24, 5);
    send_byte(8'h0A);
    check_val("t3_cursor", bus.cursor, 1925);

    // Printable in the last cell
    goto_cell(24, 79);
    send_byte(8'h7A);
    check_val("t4_cursor", bus.cursor, 1920);

    // Control characters
    goto_cell(1, 3);
    send_byte(8'h08);
    check_val("t5_bs", bus.cursor, 82);
    send_byte(8'h0D);
    check_val("t5_cr", bus.cursor, 80);
    send_byte(8'h08);
    check_val("t5_bs_col0", bus.cursor, 80);
    send_byte(8'h0C);
    check_val("t5_ff", bus.cursor, 0);
    send_byte(8'h07);
    check_val("t5_ignored", bus.cursor, 0);

    // Randomized mix
    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 99);
      if (pick < 55)      rb = 8'($urandom_range(8'h20, 8'h7E));
      else if (pick < 70) rb = 8'h0A;
      else if (pick < 78) rb = 8'h0D;
      else if (pick < 88) rb = 8'h08;
      else if (pick < 90) rb = 8'h0C;
      else                rb = 8'($urandom);
      send_byte(rb);
    end

    // Reset during the scroll wait
    goto_cell(24, 5);
    @(negedge clk100);
    bus.rx_data  = 8'h0A;
    bus.rx_valid = 1'b1;
    @(posedge clk100);
    #1;
    bus.rx_valid = 1'b0;
    @(negedge clk100);
    check_val("t6_copy_start", bus.wr_start, 1);
    check_val("t6_copy_offset", bus.wr_offset, COLS);
    @(negedge clk100);
    rst = 1'b1;
    @(negedge clk100);
    check_val("t6_rst_wr_start", bus.wr_start, 0);
    check_val("t6_rst_cursor", bus.cursor, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk100);
    bus.wr_complete = 1'b1;
    @(negedge clk100);
    bus.wr_complete = 1'b0;
    check_val("t6_late_wr_start", bus.wr_start, 0);
    check_val("t6_late_rx_ready", bus.rx_ready, 1);
    check_val("t6_late_cursor", bus.cursor, 0);
    @(negedge clk100);
    check_val("t6_late_wr_start2", bus.wr_start, 0);
    m_row = 0;
    m_col = 0;
    exp_q.delete();
    send_byte(8'h42);
    check_val("t6_after_cursor", bus.cursor, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
